// File: rtl/lh_message_sender.sv
// lh_message_sender: buffers printable host bytes, then frames them to a hasher
// as 0xFF, body bytes, 0x00 and captures the returned 64-bit digest.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | accept host writes into the FIFO, wait for start
//   HEAD  | present 0xFF frame marker until the hasher takes it
//   BODY  | present FIFO head, pop on each byte_ready
//   TAIL  | present 0x00 frame terminator until the hasher takes it
//   WAIT  | wait for digest_ready, bounded by TIMEOUT cycles
//   DONE  | one-cycle hash_valid pulse, then back to IDLE
module lh_message_sender #(
  parameter int MAX_LEN = 32,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  wr_byte,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic        start,
  output logic [7:0]  message_byte,
  output logic        message_valid,
  input  logic        byte_ready,
  input  logic [63:0] digest,
  input  logic        digest_ready,
  output logic [63:0] hash_out,
  output logic        hash_valid,
  output logic        busy,
  output logic        err_invalid,
  output logic        err_timeout
);

  localparam int PW = $clog2(MAX_LEN);
  localparam int CW = $clog2(MAX_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEAD,
    S_BODY,
    S_TAIL,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic [7:0]    mem [MAX_LEN];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;
  logic          accept;
  logic          printable;
  logic          push;

  assign wr_ready  = (state == S_IDLE) && (count < CW'(MAX_LEN));
  assign busy      = (state != S_IDLE);
  assign accept    = wr_valid && wr_ready;
  assign printable = (wr_byte >= 8'h20) && (wr_byte <= 8'h7E);
  assign push      = accept && printable;
  // Pointers are exactly log2(MAX_LEN) bits, so the increment wraps on its own.
  assign rd_next   = rd_ptr + 1'b1;

  // FIFO storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= wr_byte;
    end
  end

  // Sequencer: FIFO bookkeeping, framing outputs, digest capture and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      timer         <= '0;
      message_byte  <= 8'h00;
      message_valid <= 1'b0;
      hash_out      <= '0;
      hash_valid    <= 1'b0;
      err_invalid   <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      hash_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (printable) begin
              wr_ptr <= wr_ptr + 1'b1;
              count  <= count + 1'b1;
            end else begin
              err_invalid <= 1'b1;
            end
          end
          if (start && (count != '0)) begin
            state         <= S_HEAD;
            message_byte  <= 8'hFF;
            message_valid <= 1'b1;
          end
        end
        S_HEAD: begin
          if (byte_ready) begin
            state        <= S_BODY;
            message_byte <= mem[rd_ptr];
          end
        end
        S_BODY: begin
          if (byte_ready) begin
            rd_ptr <= rd_next;
            count  <= count - 1'b1;
            if (count == CW'(1)) begin
              state        <= S_TAIL;
              message_byte <= 8'h00;
            end else begin
              message_byte <= mem[rd_next];
            end
          end
        end
        S_TAIL: begin
          if (byte_ready) begin
            state         <= S_WAIT;
            message_byte  <= 8'h00;
            message_valid <= 1'b0;
            timer         <= '0;
          end
        end
        S_WAIT: begin
          // A digest arriving on the last allowed cycle still counts as success.
          if (digest_ready) begin
            hash_out   <= digest;
            hash_valid <= 1'b1;
            state      <= S_DONE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lh_message_sender.sv
// tb_lh_message_sender: directed vector table plus hand-written multi-cycle
// sequences for timeout, reset mid-message and full-buffer behaviour.
module tb_lh_message_sender;

  localparam logic [63:0] D1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] D2 = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] D3 = 64'h1122334455667788;
  localparam logic [63:0] D4 = 64'hA5A5A5A55A5A5A5A;

  logic        clk;
  logic        rst;
  logic [7:0]  wr_byte;
  logic        wr_valid;
  logic        wr_ready;
  logic        start;
  logic [7:0]  message_byte;
  logic        message_valid;
  logic        byte_ready;
  logic [63:0] digest;
  logic        digest_ready;
  logic [63:0] hash_out;
  logic        hash_valid;
  logic        busy;
  logic        err_invalid;
  logic        err_timeout;

  int checks = 0;
  int failures = 0;

  lh_message_sender #(.MAX_LEN(32), .TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .wr_byte(wr_byte), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .start(start), .message_byte(message_byte),
    .message_valid(message_valid), .byte_ready(byte_ready), .digest(digest),
    .digest_ready(digest_ready), .hash_out(hash_out), .hash_valid(hash_valid),
    .busy(busy), .err_invalid(err_invalid), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wv;
    logic [7:0]  wb;
    logic        st;
    logic        br;
    logic        dr;
    logic [63:0] dg;
    logic        e_wrdy;
    logic        e_mv;
    logic [7:0]  e_mb;
    logic        e_busy;
    logic        e_hv;
    logic        e_ei;
    logic [63:0] e_ho;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic wv, input logic [7:0] wb, input logic st,
                     input logic br, input logic dr, input logic [63:0] dg,
                     input logic e_wrdy, input logic e_mv, input logic [7:0] e_mb,
                     input logic e_busy, input logic e_hv, input logic e_ei,
                     input logic [63:0] e_ho);
    vec_t v;
    v.wv = wv; v.wb = wb; v.st = st; v.br = br; v.dr = dr; v.dg = dg;
    v.e_wrdy = e_wrdy; v.e_mv = e_mv; v.e_mb = e_mb; v.e_busy = e_busy;
    v.e_hv = e_hv; v.e_ei = e_ei; v.e_ho = e_ho;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_byte  = b;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] eb;

    rst = 1'b1; wr_byte = 8'h00; wr_valid = 1'b0; start = 1'b0;
    byte_ready = 1'b0; digest = '0; digest_ready = 1'b0;

    // wv  wb    st br dr dg   | wrdy mv mb    busy hv ei ho
    // "abc" message, digest one cycle after tail
    add(1, 8'h61, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h62, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 0, 0);
    add(1, 8'h63, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0,    1, 0, 8'h00, 0, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'hFF, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h61, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h62, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h63, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h00, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 1, D1,   0, 0, 8'h00, 1, 0, 0, 0);
    add(0, 8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 1, 1, 0, D1);
    // 0x41, 0x0A (rejected), 0x42
    add(1, 8'h41, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 0, D1);
    add(1, 8'h0A, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 0, D1);
    add(1, 8'h42, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 1, D1);
    add(0, 8'h00, 1, 1, 0, 0,    1, 0, 8'h00, 0, 0, 1, D1);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'hFF, 1, 0, 1, D1);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h41, 1, 0, 1, D1);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h42, 1, 0, 1, D1);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h00, 1, 0, 1, D1);
    add(0, 8'h00, 0, 1, 1, D2,   0, 0, 8'h00, 1, 0, 1, D1);
    add(0, 8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 1, 1, 1, D2);
    // "xyz" with byte_ready toggling in BODY; start while busy is ignored
    add(1, 8'h78, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 1, D2);
    add(1, 8'h79, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 1, D2);
    add(1, 8'h7A, 0, 1, 0, 0,    1, 0, 8'h00, 0, 0, 1, D2);
    add(0, 8'h00, 1, 0, 0, 0,    1, 0, 8'h00, 0, 0, 1, D2);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'hFF, 1, 0, 1, D2);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h78, 1, 0, 1, D2);
    add(0, 8'h00, 0, 0, 0, 0,    0, 1, 8'h79, 1, 0, 1, D2);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h79, 1, 0, 1, D2);
    add(0, 8'h00, 1, 0, 0, 0,    0, 1, 8'h7A, 1, 0, 1, D2);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h7A, 1, 0, 1, D2);
    add(0, 8'h00, 0, 0, 0, 0,    0, 1, 8'h00, 1, 0, 1, D2);
    add(0, 8'h00, 0, 1, 0, 0,    0, 1, 8'h00, 1, 0, 1, D2);
    add(0, 8'h00, 0, 0, 0, 0,    0, 0, 8'h00, 1, 0, 1, D2);

    // reset state
    repeat (2) @(negedge clk);
    check("reset_wr_ready", 64'(wr_ready), 64'(1'b1));
    check("reset_busy", 64'(busy), 64'(1'b0));
    check("reset_mv", 64'(message_valid), 64'(1'b0));
    check("reset_ho", hash_out, 64'h0);
    check("reset_errs", 64'({err_invalid, err_timeout}), 64'(2'b00));
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      wr_valid = vq[i].wv; wr_byte = vq[i].wb; start = vq[i].st;
      byte_ready = vq[i].br; digest_ready = vq[i].dr; digest = vq[i].dg;
      check($sformatf("r%0d_wr_ready", i), 64'(wr_ready), 64'(vq[i].e_wrdy));
      check($sformatf("r%0d_mv", i), 64'(message_valid), 64'(vq[i].e_mv));
      check($sformatf("r%0d_mb", i), 64'(message_byte), 64'(vq[i].e_mb));
      check($sformatf("r%0d_busy", i), 64'(busy), 64'(vq[i].e_busy));
      check($sformatf("r%0d_hv", i), 64'(hash_valid), 64'(vq[i].e_hv));
      check($sformatf("r%0d_ei", i), 64'(err_invalid), 64'(vq[i].e_ei));
      check($sformatf("r%0d_et", i), 64'(err_timeout), 64'(1'b0));
      check($sformatf("r%0d_ho", i), hash_out, vq[i].e_ho);
    end

    // Timeout: the last table row was WAIT cycle 0; expire after 255 WAIT cycles
    bad = 0;
    for (int k = 1; k <= 254; k++) begin
      @(negedge clk);
      if (busy !== 1'b1 || hash_valid !== 1'b0 || err_timeout !== 1'b0 ||
          message_valid !== 1'b0) bad++;
    end
    check("timeout_wait_hold", 64'(bad), 64'(0));
    @(negedge clk);
    check("timeout_busy", 64'(busy), 64'(1'b0));
    check("timeout_err", 64'(err_timeout), 64'(1'b1));
    check("timeout_hv", 64'(hash_valid), 64'(1'b0));
    check("timeout_ho", hash_out, D2);

    // Reset during BODY, then a 1-byte message
    wr(8'h41); wr(8'h42); wr(8'h43);
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b1; byte_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("rst_head_mb", 64'(message_byte), 64'(8'hFF));
    @(negedge clk);
    check("rst_body_mb", 64'(message_byte), 64'(8'h41));
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_mv", 64'(message_valid), 64'(1'b0));
    check("rst_mid_mb", 64'(message_byte), 64'(8'h00));
    check("rst_mid_busy", 64'(busy), 64'(1'b0));
    check("rst_mid_hv", 64'(hash_valid), 64'(1'b0));
    check("rst_mid_ho", hash_out, 64'h0);
    check("rst_mid_errs", 64'({err_invalid, err_timeout}), 64'(2'b00));
    rst = 1'b0;
    @(negedge clk);
    check("rst_after_wr_ready", 64'(wr_ready), 64'(1'b1));
    wr_valid = 1'b1; wr_byte = 8'h51;
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("one_head", 64'({message_valid, message_byte}), 64'({1'b1, 8'hFF}));
    @(negedge clk);
    check("one_body", 64'({message_valid, message_byte}), 64'({1'b1, 8'h51}));
    @(negedge clk);
    check("one_tail", 64'({message_valid, message_byte}), 64'({1'b1, 8'h00}));
    @(negedge clk);
    check("one_wait", 64'({busy, message_valid}), 64'(2'b10));

    // Digest on the very last WAIT cycle: capture wins over timeout
    for (int k = 1; k <= 253; k++) @(negedge clk);
    @(negedge clk);
    digest_ready = 1'b1; digest = D3;
    @(negedge clk);
    digest_ready = 1'b0;
    check("edge_hv", 64'(hash_valid), 64'(1'b1));
    check("edge_ho", hash_out, D3);
    check("edge_et", 64'(err_timeout), 64'(1'b0));
    @(negedge clk);
    check("edge_idle", 64'({busy, hash_valid, err_timeout}), 64'(3'b000));

    // Full buffer: 32 writes fill it, 33rd is dropped, 34 valid cycles follow
    for (int j = 0; j < 32; j++) wr(8'(8'h20 + j));
    @(negedge clk);
    check("full_wr_ready", 64'(wr_ready), 64'(1'b0));
    wr_byte = 8'h40;
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b1; byte_ready = 1'b1;
    check("full_no_err", 64'(err_invalid), 64'(1'b0));
    for (int j = 0; j < 34; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (j == 0) eb = 8'hFF;
      else if (j == 33) eb = 8'h00;
      else eb = 8'(8'h1F + j);
      check($sformatf("full_b%0d", j), 64'({message_valid, message_byte}), 64'({1'b1, eb}));
    end
    @(negedge clk);
    check("full_wait", 64'({busy, message_valid}), 64'(2'b10));
    digest_ready = 1'b1; digest = D4;
    @(negedge clk);
    digest_ready = 1'b0;
    check("full_hv", 64'(hash_valid), 64'(1'b1));
    check("full_ho", hash_out, D4);
    @(negedge clk);
    check("full_idle", 64'({busy, hash_valid, wr_ready}), 64'(3'b001));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
